// File: rtl/rd_arb_pkg.sv
// Shared types and width helpers for the read-domain FIFO arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   src_width() : width of a source index for a given port count
//   cnt_width() : width of the burst word counter for a given burst length
package rd_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int unsigned D_SIZE_DEF    = 16;
   localparam int unsigned N_REQ_DEF     = 2;
   localparam int unsigned BURST_LEN_DEF = 4;

   // Source index width; at least one bit even for degenerate counts.
   function automatic int unsigned src_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Counter must be able to hold BURST_LEN itself.
   function automatic int unsigned cnt_width(input int unsigned b);
      return (b < 1) ? 1 : $clog2(b + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-non-empty finder.
// Scans req starting at ptr and wrapping modulo N_REQ; returns the first
// set index. N_REQ need not be a power of two.
//   req    in  N_REQ  request vector (1 = source has data)
//   ptr    in  SRC_W  scan start index, always < N_REQ
//   winner out SRC_W  first requesting index at or after ptr
//   any    out 1      at least one request is set
module rr_pick
   import rd_arb_pkg::*;
#(
   parameter  int unsigned N_REQ = N_REQ_DEF,
   localparam int unsigned SRC_W = src_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SRC_W-1:0] ptr,
   output logic [SRC_W-1:0] winner,
   output logic             any
);

   // Modulo-N_REQ addition without a divider.
   function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base,
                                                 input int unsigned       off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return SRC_W'(s);
   endfunction

   // Scan from farthest to nearest offset so the nearest requester wins.
   always_comb begin
      winner = '0;
      any    = |req;
      for (int unsigned off = N_REQ; off > 0; off--) begin
         if (req[wrap_idx(ptr, off - 1)]) winner = wrap_idx(ptr, off - 1);
      end
   end

endmodule

// File: rtl/rd_fifo_arbiter.sv
// Read-domain arbiter draining N_REQ first-word-fall-through FIFOs into one
// valid/ready consumer. Round-robin grants with bursts of up to BURST_LEN
// words keep each source's words contiguous. The selected FIFO is popped with
// a combinational one-cycle pulse and its head word is captured into a
// one-entry output register.
// Optional feature macro: RD_ARB_PRIO_EN (source 0 strict priority, with
// preemption of bursts held by other sources).
//   i_r_clk   in  1             read-domain clock
//   i_r_rstn  in  1             asynchronous active-low reset
//   i_empty   in  N_REQ         per-FIFO empty flag
//   i_r_data  in  N_REQ*D_SIZE  per-FIFO head word (slot k at k*D_SIZE)
//   o_r_inc   out N_REQ         per-FIFO pop pulse (combinational)
//   o_valid   out 1             output register holds a word
//   o_data    out D_SIZE        captured word
//   o_src     out SRC_W         FIFO index that supplied o_data
//   i_ready   in  1             consumer accepts o_data this cycle
//   o_busy    out 1             a burst grant is held
module rd_fifo_arbiter
   import rd_arb_pkg::*;
#(
   parameter  int unsigned D_SIZE    = D_SIZE_DEF,
   parameter  int unsigned N_REQ     = N_REQ_DEF,
   parameter  int unsigned BURST_LEN = BURST_LEN_DEF,
   localparam int unsigned SRC_W     = src_width(N_REQ)
) (
   input  logic                    i_r_clk,
   input  logic                    i_r_rstn,
   input  logic [N_REQ-1:0]        i_empty,
   input  logic [N_REQ*D_SIZE-1:0] i_r_data,
   output logic [N_REQ-1:0]        o_r_inc,
   output logic                    o_valid,
   output logic [D_SIZE-1:0]       o_data,
   output logic [SRC_W-1:0]        o_src,
   input  logic                    i_ready,
   output logic                    o_busy
);

   localparam int unsigned      CNT_W    = cnt_width(BURST_LEN);
   localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);

   arb_state_e        state, state_n;
   logic [SRC_W-1:0]  rr_ptr, rr_ptr_n;
   logic [SRC_W-1:0]  grant, grant_n;
   logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
   logic [SRC_W-1:0]  pick_idx, win_idx, pop_idx;
   logic              pick_any, pop, load_ok;
   logic [N_REQ-1:0]  req;
   logic [D_SIZE-1:0] pop_data;

   // Source index following s, wrapping at N_REQ-1.
   function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
      return (s == LAST_SRC) ? '0 : s + SRC_W'(1);
   endfunction

   assign load_ok = ~o_valid | i_ready;
   assign req     = ~i_empty;
   assign cnt_inc = cnt + CNT_W'(1);

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .winner (pick_idx),
      .any    (pick_any)
   );

`ifdef RD_ARB_PRIO_EN
   logic preempt;
   // Source 0 overrides the round-robin pick and ends other sources' bursts.
   assign win_idx = i_empty[0] ? pick_idx : '0;
   assign preempt = (grant != '0) & ~i_empty[0] & load_ok;
`else
   assign win_idx = pick_idx;
`endif

   // Next-state and pop decision.
   always_comb begin
      state_n  = state;
      rr_ptr_n = rr_ptr;
      grant_n  = grant;
      cnt_n    = cnt;
      pop      = 1'b0;
      pop_idx  = grant;
      case (state)
         IDLE: begin
            if (load_ok && pick_any) begin
               pop     = 1'b1;
               pop_idx = win_idx;
               grant_n = win_idx;
               cnt_n   = CNT_W'(1);
               if (BURST_LEN == 1) rr_ptr_n = next_src(win_idx);
               else                state_n  = BURST;
            end
         end
         BURST: begin
            if (i_empty[grant]) begin
               state_n  = IDLE;
               rr_ptr_n = next_src(grant);
            end
`ifdef RD_ARB_PRIO_EN
            else if (preempt) begin
               state_n  = IDLE;
               rr_ptr_n = next_src(grant);
            end
`endif
            else if (load_ok) begin
               pop   = 1'b1;
               cnt_n = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  state_n  = IDLE;
                  rr_ptr_n = next_src(grant);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Head word of the FIFO being popped.
   always_comb begin
      pop_data = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (pop_idx == SRC_W'(k)) pop_data = i_r_data[k*D_SIZE +: D_SIZE];
      end
   end

   // Pop pulse; gated by reset so no FIFO advances while the block is held.
   always_comb begin
      o_r_inc = '0;
      if (pop && i_r_rstn) o_r_inc[pop_idx] = 1'b1;
   end

   // FSM and arbitration state.
   always_ff @(posedge i_r_clk or negedge i_r_rstn) begin
      if (!i_r_rstn) begin
         state  <= IDLE;
         rr_ptr <= '0;
         grant  <= '0;
         cnt    <= '0;
         o_busy <= 1'b0;
      end else begin
         state  <= state_n;
         rr_ptr <= rr_ptr_n;
         grant  <= grant_n;
         cnt    <= cnt_n;
         o_busy <= (state_n == BURST);
      end
   end

   // One-entry output register; drained by i_ready when nothing replaces it.
   always_ff @(posedge i_r_clk or negedge i_r_rstn) begin
      if (!i_r_rstn) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_src   <= '0;
      end else if (pop) begin
         o_valid <= 1'b1;
         o_data  <= pop_data;
         o_src   <= pop_idx;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule
